// File: rtl/enigma_key_sequencer.sv
// Keypress sequencer for the Enigma datapath: buffers key codes, steps the rotors,
// waits for the knock cascade to settle, runs one substitution and presents the result.
module enigma_key_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ROT_HIGH   = 2,
   parameter int SETTLE     = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       key_valid,
   input  logic [4:0] key_code,
   output logic       key_ready,
   input  logic       settings_load,
   output logic       rotor_load,
   output logic       rotate,
   output logic       enc_start,
   output logic [4:0] enc_letter,
   input  logic       enc_done,
   input  logic [4:0] enc_result,
   output logic       out_valid,
   output logic [4:0] out_code,
   input  logic       out_ready,
   output logic       busy,
   output logic       err_badkey,
   output logic       err_timeout,
   output logic [2:0] dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PMAX = (ROT_HIGH > SETTLE) ? ROT_HIGH : SETTLE;
   localparam int PW = $clog2(PMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_STEP   = 3'd2,
      S_SETTLE = 3'd3,
      S_ENCODE = 3'd4,
      S_WAIT   = 3'd5,
      S_OUTPUT = 3'd6
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_phase;
   logic [TW-1:0] r_tmo;
   logic          r_load_pending;

   logic [4:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_accept;
   logic          w_bad;
   logic          w_push;
   logic          w_pop;

   // Both handshakes are valid/ready: a transfer happens on the rising edge where
   // valid and ready are both high; valid never waits on ready, and an offered
   // out_code stays stable until it is taken.
   assign key_ready = (r_count < CW'(FIFO_DEPTH));
   assign w_accept  = key_valid & key_ready;
   assign w_bad     = (key_code > 5'd25);
   assign w_push    = w_accept & ~w_bad;
   assign w_pop     = (r_state == S_ENCODE);

   assign busy      = (r_state != S_IDLE) || (r_count != '0) || r_load_pending;
   assign dbg_state = r_state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= key_code;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_phase        <= '0;
         r_tmo          <= '0;
         r_load_pending <= 1'b0;
         rotor_load     <= 1'b0;
         rotate         <= 1'b0;
         enc_start      <= 1'b0;
         enc_letter     <= '0;
         out_valid      <= 1'b0;
         out_code       <= '0;
         err_badkey     <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         rotor_load <= 1'b0;
         enc_start  <= 1'b0;
         if (settings_load)     r_load_pending <= 1'b1;
         if (w_accept && w_bad) err_badkey     <= 1'b1;

         case (r_state)
            S_IDLE: begin
               // A pending rotor reload goes first so a waiting key steps from the new start.
               if (r_load_pending) begin
                  r_state    <= S_LOAD;
                  rotor_load <= 1'b1;
               end else if (r_count != '0) begin
                  r_state <= S_STEP;
                  rotate  <= 1'b1;
                  r_phase <= '0;
               end
            end
            S_LOAD: begin
               r_load_pending <= settings_load;
               err_timeout    <= 1'b0;
               err_badkey     <= w_accept & w_bad;
               r_state        <= S_IDLE;
            end
            S_STEP: begin
               if (r_phase == PW'(ROT_HIGH - 1)) begin
                  rotate  <= 1'b0;
                  r_phase <= '0;
                  r_state <= S_SETTLE;
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            S_SETTLE: begin
               if (r_phase == PW'(SETTLE - 1)) begin
                  enc_start  <= 1'b1;
                  enc_letter <= r_mem[r_rd_ptr];
                  r_state    <= S_ENCODE;
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            S_ENCODE: begin
               // The enc_start cycle already counts as one elapsed timeout cycle.
               r_tmo   <= TW'(1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (enc_done) begin
                  out_code  <= enc_result;
                  out_valid <= 1'b1;
                  r_state   <= S_OUTPUT;
               end else if (r_tmo >= TW'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (r_tmo != '1) begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            S_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Bench for enigma_key_sequencer: single-key vector table, hand-written corner
// sequences and a randomized run scored against an in-order letter model.
module tb_enigma_key_sequencer;

   localparam logic [17:0] RESET_OUTS = {1'b1, 17'b0};

   logic       clock;
   logic       reset_n;
   logic       key_valid;
   logic [4:0] key_code;
   logic       key_ready;
   logic       settings_load;
   logic       rotor_load;
   logic       rotate;
   logic       enc_start;
   logic [4:0] enc_letter;
   logic       enc_done;
   logic [4:0] enc_result;
   logic       out_valid;
   logic [4:0] out_code;
   logic       out_ready;
   logic       busy;
   logic       err_badkey;
   logic       err_timeout;
   logic [2:0] dbg_state;

   enigma_key_sequencer dut (
      .clock(clock), .reset_n(reset_n),
      .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
      .settings_load(settings_load), .rotor_load(rotor_load), .rotate(rotate),
      .enc_start(enc_start), .enc_letter(enc_letter),
      .enc_done(enc_done), .enc_result(enc_result),
      .out_valid(out_valid), .out_code(out_code), .out_ready(out_ready),
      .busy(busy), .err_badkey(err_badkey), .err_timeout(err_timeout),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // datapath responder controls
   bit dp_enable = 1'b1;
   int dp_dmin   = 1;
   int dp_dmax   = 1;
   int dp_offset = 0;
   bit rand_ready = 1'b0;

   // monitor state
   int cyc = 0;
   int rot_rises = 0, rot_high = 0, loads = 0, starts = 0;
   int rot_edge = 0, load_edge = 0, es_edge = 0, done_edge = 0, ov_edge = 0, to_edge = 0;
   logic [4:0] es_letter = '0;
   logic prev_rot = 1'b0, prev_ov = 1'b0, prev_to = 1'b0;
   logic [4:0] obs_q[$];
   int obs_rd = 0;

   // scoreboard
   logic [4:0] exp_q[$];

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(negedge clock);
      if (out_valid && out_ready) obs_q.push_back(out_code);
      if (out_valid && !prev_ov) ov_edge = cyc;
      if (rotate) rot_high++;
      if (rotate && !prev_rot) begin rot_rises++; rot_edge = cyc; end
      if (rotor_load) begin loads++; load_edge = cyc; end
      if (enc_start) begin starts++; es_edge = cyc; es_letter = enc_letter; end
      if (enc_done) done_edge = cyc;
      if (err_timeout && !prev_to) to_edge = cyc;
      prev_rot = rotate;
      prev_ov  = out_valid;
      prev_to  = err_timeout;
   end

   // substitution datapath model: result = (letter + offset) mod 26
   initial begin
      logic [4:0] letter;
      int d;
      enc_done   = 1'b0;
      enc_result = '0;
      forever begin
         @(posedge clock);
         #2;
         if (enc_start && dp_enable) begin
            letter = enc_letter;
            d = $urandom_range(dp_dmax, dp_dmin);
            repeat (d) @(posedge clock);
            #2;
            enc_result = 5'((int'(letter) + dp_offset) % 26);
            enc_done   = 1'b1;
            @(posedge clock);
            #2;
            enc_done = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic logic [17:0] outs_packed();
      return {key_ready, rotor_load, rotate, enc_start, enc_letter,
              out_valid, out_code, busy, err_badkey, err_timeout};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      key_valid     = 1'b0;
      key_code      = '0;
      settings_load = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic send_key(input logic [4:0] code, input int max_wait, output bit ok);
      bit acc;
      ok = 1'b0;
      key_valid = 1'b1;
      key_code  = code;
      for (int n = 0; n < max_wait && !ok; n++) begin
         @(negedge clock);
         acc = key_ready;
         tick();
         ok = acc;
      end
      key_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      check("idle_reached", int'(busy), 0);
   endtask

   task automatic wait_start(input int s0, input int max_cycles);
      int n = 0;
      while (starts == s0 && n < max_cycles) begin
         tick();
         n++;
      end
      check("enc_start_seen", int'(starts != s0), 1);
   endtask

   task automatic pulse_settings_load();
      settings_load = 1'b1;
      tick();
      settings_load = 1'b0;
   endtask

   task automatic check_outputs(input string name);
      logic [4:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_rd < obs_q.size()) begin
            check(name, int'(obs_q[obs_rd]), int'(e));
            obs_rd++;
         end else begin
            check({name, "_missing"}, -1, int'(e));
         end
      end
      check({name, "_extra"}, obs_q.size() - obs_rd, 0);
   endtask

   typedef struct {
      logic [4:0] code;
      int         delay;
      int         offset;
      bit         good;
      logic [4:0] exp_out;
   } vec_t;

   vec_t vecs[5];
   bit ok;
   int e0, r0, r1, h0, o0, l0, s0, n, n_good;
   bit bad_seen;
   logic [4:0] code;

   initial begin
      reset_n       = 1'b0;
      key_valid     = 1'b0;
      key_code      = '0;
      settings_load = 1'b0;
      out_ready     = 1'b1;

      vecs[0] = '{5'd0,  2, 17, 1'b1, 5'd17};
      vecs[1] = '{5'd25, 1, 3,  1'b1, 5'd2};
      vecs[2] = '{5'd13, 5, 0,  1'b1, 5'd13};
      vecs[3] = '{5'd26, 1, 0,  1'b0, 5'd0};
      vecs[4] = '{5'd31, 1, 0,  1'b0, 5'd0};

      // single keypress table
      for (int v = 0; v < 5; v++) begin
         do_reset();
         check("reset_outputs", int'(outs_packed()), int'(RESET_OUTS));
         dp_dmin   = vecs[v].delay;
         dp_dmax   = vecs[v].delay;
         dp_offset = vecs[v].offset;
         r0 = rot_rises; h0 = rot_high; o0 = obs_q.size(); s0 = starts;
         key_valid = 1'b1;
         key_code  = vecs[v].code;
         tick();
         e0 = cyc;
         key_valid = 1'b0;
         check("vec_busy", int'(busy), int'(vecs[v].good));
         wait_idle(200);
         repeat (5) tick();
         check("vec_rotates", rot_rises - r0, int'(vecs[v].good));
         check("vec_rot_high", rot_high - h0, vecs[v].good ? 2 : 0);
         check("vec_badkey", int'(err_badkey), int'(!vecs[v].good));
         check("vec_out_count", obs_q.size() - o0, int'(vecs[v].good));
         if (vecs[v].good) begin
            check("vec_start_edge", es_edge - e0, 7);
            check("vec_letter", int'(es_letter), int'(vecs[v].code));
            check("vec_out_latency", ov_edge - done_edge, 1);
            check("vec_out_code", int'(obs_q[obs_q.size() - 1]), int'(vecs[v].exp_out));
         end else begin
            check("vec_no_start", starts - s0, 0);
         end
      end

      // backpressure: consumer stalled, FIFO fills, then drains in order
      do_reset();
      dp_dmin = 1; dp_dmax = 1; dp_offset = 0;
      out_ready = 1'b0;
      r0 = rot_rises;
      obs_rd = obs_q.size();
      exp_q.delete();
      for (int k = 1; k <= 5; k++) begin
         send_key(5'(k), 50, ok);
         check("bp_accept", int'(ok), 1);
         exp_q.push_back(5'(k));
      end
      check("bp_ready_low", int'(key_ready), 0);
      send_key(5'd6, 10, ok);
      check("bp_stall", int'(ok), 0);
      out_ready = 1'b1;
      send_key(5'd6, 200, ok);
      check("bp_accept6", int'(ok), 1);
      exp_q.push_back(5'd6);
      wait_idle(500);
      check_outputs("bp_order");
      check("bp_rotates", rot_rises - r0, 6);

      // settings_load while waiting on the datapath is deferred past the output
      do_reset();
      dp_dmin = 3; dp_dmax = 3; dp_offset = 0;
      out_ready = 1'b0;
      l0 = loads; r0 = rot_rises; s0 = starts;
      obs_rd = obs_q.size();
      send_key(5'd7, 50, ok);
      send_key(5'd8, 50, ok);
      exp_q.push_back(5'd7);
      exp_q.push_back(5'd8);
      wait_start(s0, 50);
      pulse_settings_load();
      repeat (20) tick();
      check("ld_deferred", loads - l0, 0);
      out_ready = 1'b1;
      wait_idle(300);
      check("ld_once", loads - l0, 1);
      check("ld_before_rotate", int'(load_edge < rot_edge), 1);
      check("ld_rotates", rot_rises - r0, 2);
      check_outputs("ld_out");

      // datapath timeout, then a normal key, then clearing by settings_load
      do_reset();
      dp_enable = 1'b0;
      o0 = obs_q.size(); s0 = starts;
      send_key(5'd5, 50, ok);
      wait_start(s0, 50);
      n = 0;
      while (!err_timeout && n < 150) begin
         tick();
         n++;
      end
      tick();
      check("to_delay", to_edge - es_edge, 64);
      check("to_no_output", obs_q.size() - o0, 0);
      wait_idle(20);
      dp_enable = 1'b1;
      dp_dmin = 2; dp_dmax = 2; dp_offset = 4;
      obs_rd = obs_q.size();
      send_key(5'd9, 50, ok);
      exp_q.push_back(5'd13);
      wait_idle(200);
      check_outputs("to_next");
      check("to_sticky", int'(err_timeout), 1);
      pulse_settings_load();
      wait_idle(20);
      check("to_cleared", int'(err_timeout), 0);
      // enc_done landing on the expiry cycle still counts
      dp_dmin = 63; dp_dmax = 63;
      send_key(5'd20, 50, ok);
      exp_q.push_back(5'd24);
      wait_idle(300);
      check_outputs("to_edge_done");
      check("to_edge_no_err", int'(err_timeout), 0);

      // asynchronous reset in the middle of the rotate window
      do_reset();
      dp_dmin = 1; dp_dmax = 1; dp_offset = 0;
      send_key(5'd3, 50, ok);
      tick();
      check("rst_rot_high", int'(rotate), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_rotate", int'(rotate), 0);
      check("rst_async_outputs", int'(outs_packed()), int'(RESET_OUTS));
      tick();
      tick();
      reset_n = 1'b1;
      r1 = rot_rises; o0 = obs_q.size();
      tick();
      check("rst_fifo_empty", int'(busy), 0);
      check("rst_key_ready", int'(key_ready), 1);
      repeat (20) tick();
      check("rst_key_lost", rot_rises - r1, 0);
      check("rst_no_output", obs_q.size() - o0, 0);

      // randomized keys, datapath latency and consumer backpressure
      do_reset();
      dp_dmin = 1; dp_dmax = 6; dp_offset = 11;
      rand_ready = 1'b1;
      r0 = rot_rises;
      obs_rd = obs_q.size();
      n_good = 0;
      bad_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         code = 5'($urandom_range(0, 31));
         repeat ($urandom_range(0, 3)) tick();
         send_key(code, 400, ok);
         check("rand_accept", int'(ok), 1);
         if (code > 5'd25) begin
            bad_seen = 1'b1;
         end else begin
            exp_q.push_back(5'((int'(code) + 11) % 26));
            n_good++;
         end
      end
      wait_idle(3000);
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      check_outputs("rand_out");
      check("rand_rotates", rot_rises - r0, n_good);
      check("rand_badkey", int'(err_badkey), int'(bad_seen));
      check("rand_no_timeout", int'(err_timeout), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/enigma_key_sequencer.md
Name: enigma_key_sequencer

Overview:
- Sequences one Enigma keypress end to end: buffers incoming key codes, steps the rotor block with a clean rotate pulse, and waits for the stepping and knock cascade to settle.
- Then launches the substitution datapath with the buffered letter, collects its result and presents it on a valid/ready output.
- Also owns rotor settings loads: drives the rotor block's synchronous reset input so new start positions load only between keypresses.

Parameters:
FIFO_DEPTH, 4, key buffer entries (power of two, 2..16)
ROT_HIGH, 2, cycles rotate is held high per keypress (>=1)
SETTLE, 4, cycles rotate is held low before encoding (>=3, covers rotor3->rotor2->rotor1 cascade)
TIMEOUT, 64, max cycles to wait for enc_done after enc_start

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
key_valid  in  1  key code offered
key_code  in  5  letter 0..25
key_ready  out  1  key buffer can accept
settings_load  in  1  one-cycle request to reload rotor start positions
rotor_load  out  1  one-cycle pulse to rotor block reset input
rotate  out  1  step request to rotor block
enc_start  out  1  one-cycle launch of substitution datapath
enc_letter  out  5  letter for datapath, valid with enc_start
enc_done  in  1  datapath result valid (one cycle)
enc_result  in  5  encoded letter, valid with enc_done
out_valid  out  1  encoded letter available
out_code  out  5  encoded letter
out_ready  in  1  consumer accepts out_code
busy  out  1  state != IDLE or FIFO non-empty or load pending
err_badkey  out  1  sticky: key_code > 25 was offered
err_timeout  out  1  sticky: TIMEOUT expired

Behaviour:
- Reset (async, reset_n low): state IDLE, FIFO empty, counters 0, load_pending 0; outputs key_ready 1, rotor_load 0, rotate 0, enc_start 0, enc_letter 0, out_valid 0, out_code 0, busy 0, err_badkey 0, err_timeout 0. Reset mid-operation aborts immediately; rotate drops to 0 asynchronously; the buffered key is lost.
- Key FIFO: key_ready = (count < FIFO_DEPTH), registered count. Push on key_valid & key_ready.
- Codes > 25 are accepted (handshake completes), not stored, and set err_badkey.
- Pop occurs only in ENCODE. Push and pop in the same cycle are both honoured; key_ready does not rise in the pop cycle itself.
- settings_load sets load_pending in any state; repeated requests merge.
- FSM:
  - IDLE: if load_pending -> LOAD; else if FIFO non-empty -> STEP; load has priority over a waiting key.
  - LOAD: rotor_load=1 for exactly one cycle; clear load_pending, err_timeout, err_badkey -> IDLE.
  - STEP: rotate=1 for ROT_HIGH cycles -> SETTLE_ST.
  - SETTLE_ST: rotate=0 for SETTLE cycles -> ENCODE.
  - ENCODE: enc_start=1 one cycle, enc_letter=FIFO head, pop; start timeout counter -> WAIT.
  - WAIT: on enc_done, register enc_result into out_code -> OUTPUT. If TIMEOUT cycles elapse without enc_done: set err_timeout, discard the key, no output -> IDLE. enc_done in the same cycle as expiry counts as done.
  - OUTPUT: out_valid=1, out_code stable until out_ready; on handshake -> IDLE.
- Latency with an empty FIFO in IDLE:
  - Push at edge 0; rotate high from edge 1 to edge 1+ROT_HIGH.
  - enc_start asserted on edge 1+ROT_HIGH+SETTLE (edge 7 with defaults).
  - out_valid one edge after enc_done.
- enc_done outside WAIT is ignored.
- rotate is never high in two consecutive keypress sequences without at least SETTLE low cycles between, so each key gives exactly one rising edge.
- Timeout counter width: clog2(TIMEOUT+1); saturating.

Test Plan:
- Single key: key_code 0 with enc_done 2 cycles after enc_start, enc_result 17 -> one rotate high window of 2 cycles, enc_start at edge 7 with enc_letter 0, out_valid with out_code 17, busy falls after out_ready.
- Backpressure: out_ready held 0, offer 6 keys 1..6 -> first key popped; 4 more stored; key_ready low after the 5th accept; 6th stalls. Release out_ready -> outputs in order 1..6 (datapath echo), 6 rotate pulses.
- settings_load in WAIT -> no rotor_load until after OUTPUT handshake; then rotor_load pulses once before the next key's rotate. Pending key still encoded afterwards.
- Timeout: no enc_done -> err_timeout set 64 cycles after enc_start, no out_valid, next key proceeds normally. A subsequent settings_load clears err_timeout.
- Bad key: key_code 26 -> accepted, err_badkey=1, no rotate, busy stays 0.
- Reset mid-STEP: reset_n low while rotate=1 -> rotate 0 and all outputs at reset values in the same cycle; FIFO empty after release.
